// File: rtl/gb_vga_pkg.sv
// Constants and state encoding shared by the Game Boy capture and VGA read sides.
package gb_vga_pkg;

   localparam int GB_H_PIXELS    = 160;
   localparam int GB_V_PIXELS    = 144;
   localparam int GB_PIXEL_COUNT = GB_H_PIXELS * GB_V_PIXELS;
   localparam int FB_ADDR_WIDTH  = 15;
   localparam int TIMEOUT_CYCLES = 2_500_000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } cap_state_e;

endpackage

// File: rtl/gb_input_sync.sv
// Brings the asynchronous GB LCD bus into the clk domain and turns its edges
// into single-cycle strobes: pixel (px_clk falling), line and frame (sync rising).
module gb_input_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       gb_px_clk,
   input  logic       gb_hsync,
   input  logic       gb_vsync,
   input  logic [1:0] gb_dat,
   output logic       px_strobe,
   output logic       line_evt,
   output logic       frame_evt,
   output logic [1:0] dat_s
);

   // Bit 0 is the metastability flop, bit 1 the synced value, bit 2 its history.
   logic [2:0] px_q;
   logic [2:0] hs_q;
   logic [2:0] vs_q;
   logic [1:0] dat1_q;
   logic [1:0] dat2_q;

   // NOTE: non-blocking assignments let each stage take the previous stage's old value, forming a true shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_q   <= '0;
         hs_q   <= '0;
         vs_q   <= '0;
         dat1_q <= '0;
         dat2_q <= '0;
      end else begin
         px_q   <= {px_q[1:0], gb_px_clk};
         hs_q   <= {hs_q[1:0], gb_hsync};
         vs_q   <= {vs_q[1:0], gb_vsync};
         dat1_q <= gb_dat;
         dat2_q <= dat1_q;
      end
   end

   assign px_strobe = !px_q[1] && px_q[2];
   assign line_evt  = hs_q[1] && !hs_q[2];
   assign frame_evt = vs_q[1] && !vs_q[2];
   assign dat_s     = dat2_q;

endmodule

// File: rtl/gb_capture_ctrl.sv
// Write side of the Game Boy framebuffer: tracks column/line from the synced LCD
// bus, issues linear-address writes and keeps the gb_on link-alive flag.
module gb_capture_ctrl #(
   parameter int GB_H_PIXELS    = gb_vga_pkg::GB_H_PIXELS,
   parameter int GB_V_PIXELS    = gb_vga_pkg::GB_V_PIXELS,
   parameter int FB_ADDR_WIDTH  = gb_vga_pkg::FB_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = gb_vga_pkg::TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     gb_px_clk,
   input  logic                     gb_hsync,
   input  logic                     gb_vsync,
   input  logic [1:0]               gb_dat,
   output logic                     fb_we,
   output logic [FB_ADDR_WIDTH-1:0] fb_waddr,
   output logic [1:0]               fb_wdata,
   output logic                     frame_done,
   output logic                     gb_on,
   output logic                     overrun
);

   import gb_vga_pkg::cap_state_e;
   import gb_vga_pkg::ST_IDLE;
   import gb_vga_pkg::ST_CAPTURE;
   import gb_vga_pkg::ST_DONE;

   localparam int COL_W  = $clog2(GB_H_PIXELS + 1);
   localparam int LINE_W = (GB_V_PIXELS > 1) ? $clog2(GB_V_PIXELS) : 1;
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [COL_W-1:0]  COL_END   = COL_W'(GB_H_PIXELS);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(GB_H_PIXELS - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(GB_V_PIXELS - 1);
   localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   logic       px_strobe;
   logic       line_evt;
   logic       frame_evt;
   logic [1:0] dat_s;

   gb_input_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .gb_px_clk (gb_px_clk),
      .gb_hsync  (gb_hsync),
      .gb_vsync  (gb_vsync),
      .gb_dat    (gb_dat),
      .px_strobe (px_strobe),
      .line_evt  (line_evt),
      .frame_evt (frame_evt),
      .dat_s     (dat_s)
   );

   cap_state_e               state_q;
   logic [COL_W-1:0]         col_q;
   logic [LINE_W-1:0]        line_q;
   logic [FB_ADDR_WIDTH-1:0] addr_q;
   logic [TO_W-1:0]          to_cnt_q;
   logic [TO_W-1:0]          to_cnt_d;
   logic                     fb_we_q;
   logic [FB_ADDR_WIDTH-1:0] fb_waddr_q;
   logic [1:0]               fb_wdata_q;
   logic                     frame_done_q;
   logic                     gb_on_q;
   logic                     overrun_q;

   logic                     restart;
   logic                     line_adv;
   logic                     capturing;
   logic                     accept;
   logic                     drop;
   logic                     last_px;
   logic                     overrun_set;
   logic                     timeout_hit;
   logic [COL_W-1:0]         col_eff;
   logic [LINE_W-1:0]        line_eff;
   logic [FB_ADDR_WIDTH-1:0] addr_eff;

   // Position after applying this cycle's frame/line event, so a pixel arriving
   // together with an event lands at the start of the new frame or line.
   // NOTE: every always_comb output gets a default first, otherwise synthesis infers latches.
   always_comb begin
      restart   = frame_evt && (state_q != ST_IDLE);
      line_adv  = line_evt && (state_q == ST_CAPTURE) && (col_q != '0) &&
                  (line_q != LINE_LAST) && !restart;
      capturing = restart || (state_q == ST_CAPTURE);
      col_eff   = col_q;
      line_eff  = line_q;
      addr_eff  = addr_q;
      if (restart) begin
         col_eff  = '0;
         line_eff = '0;
         addr_eff = '0;
      end else if (line_adv) begin
         col_eff  = '0;
         line_eff = line_q + LINE_W'(1);
      end
      accept      = px_strobe && capturing && (col_eff < COL_END);
      drop        = px_strobe && !accept && (state_q != ST_IDLE);
      last_px     = accept && (line_eff == LINE_LAST) && (col_eff == COL_LAST);
      overrun_set = drop || (frame_evt && (state_q == ST_CAPTURE));
   end

   always_comb begin
      to_cnt_d = to_cnt_q;
      if (px_strobe) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_MAX) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   // Fires only on the cycle the counter reaches the limit, so a later VSYNC can restart capture.
   assign timeout_hit = !px_strobe && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         col_q        <= '0;
         line_q       <= '0;
         addr_q       <= '0;
         fb_we_q      <= 1'b0;
         fb_waddr_q   <= '0;
         fb_wdata_q   <= '0;
         frame_done_q <= 1'b0;
         gb_on_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else if (timeout_hit) begin
         state_q      <= ST_IDLE;
         gb_on_q      <= 1'b0;
         fb_we_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         fb_we_q      <= accept;
         frame_done_q <= last_px;
         if (accept) begin
            fb_waddr_q <= addr_eff;
            fb_wdata_q <= dat_s;
         end
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (frame_evt) begin
                  state_q <= ST_CAPTURE;
                  col_q   <= '0;
                  line_q  <= '0;
                  addr_q  <= '0;
               end
            end
            default: begin
               if (last_px) begin
                  state_q <= ST_DONE;
                  gb_on_q <= 1'b1;
               end else if (capturing) begin
                  state_q <= ST_CAPTURE;
               end
               if (capturing) begin
                  col_q  <= accept ? col_eff + COL_W'(1) : col_eff;
                  line_q <= line_eff;
                  addr_q <= (accept && !last_px) ? addr_eff + FB_ADDR_WIDTH'(1) : addr_eff;
               end
            end
         endcase
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_waddr   = fb_waddr_q;
   assign fb_wdata   = fb_wdata_q;
   assign frame_done = frame_done_q;
   assign gb_on      = gb_on_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_gb_capture_ctrl.sv
// Scoreboard bench for gb_capture_ctrl on a shrunken 8x4 frame with a 1000-cycle timeout.
module tb_gb_capture_ctrl;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int AW = 15;
   localparam int TO = 1000;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    data;
      logic          fd;
   } wr_t;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          gb_px_clk = 1'b0;
   logic          gb_hsync  = 1'b0;
   logic          gb_vsync  = 1'b0;
   logic [1:0]    gb_dat    = 2'd0;
   logic          fb_we;
   logic [AW-1:0] fb_waddr;
   logic [1:0]    fb_wdata;
   logic          frame_done;
   logic          gb_on;
   logic          overrun;

   int  n_cmp        = 0;
   int  n_err        = 0;
   int  cyc          = 0;
   int  fd_cnt       = 0;
   int  fall_cyc     = 0;
   int  first_fall   = 0;
   int  first_we_cyc = -1;
   int  last_we_cyc  = 0;
   int  to_fall      = -1;
   wr_t exp_q[$];
   wr_t mon_e;

   gb_capture_ctrl #(
      .GB_H_PIXELS    (H),
      .GB_V_PIXELS    (V),
      .FB_ADDR_WIDTH  (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gb_px_clk  (gb_px_clk),
      .gb_hsync   (gb_hsync),
      .gb_vsync   (gb_vsync),
      .gb_dat     (gb_dat),
      .fb_we      (fb_we),
      .fb_waddr   (fb_waddr),
      .fb_wdata   (fb_wdata),
      .frame_done (frame_done),
      .gb_on      (gb_on),
      .overrun    (overrun)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every write the DUT presents is popped against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (fb_we) begin
            if (first_we_cyc < 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
            if (frame_done) fd_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_we: got write addr=%0d data=%0d, required no write", fb_waddr, fb_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("waddr", 32'(fb_waddr), 32'(mon_e.addr));
               check("wdata", 32'(fb_wdata), 32'(mon_e.data));
               check("frame_done", 32'(frame_done), 32'(mon_e.fd));
            end
         end else if (frame_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_done_no_we: got frame_done=1 with fb_we=0, required both or neither");
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pixel(input logic [1:0] d);
      gb_dat    = d;
      gb_px_clk = 1'b1;
      tick(3);
      gb_px_clk = 1'b0;
      fall_cyc  = cyc;
      tick(3);
   endtask

   task automatic expect_px(input int line, input int col, input logic [1:0] d);
      exp_q.push_back('{addr: AW'(line * H + col), data: d, fd: (line == V - 1) && (col == H - 1)});
      pixel(d);
   endtask

   task automatic hline();
      gb_hsync = 1'b1;
      tick(3);
      gb_hsync = 1'b0;
      tick(3);
   endtask

   task automatic vframe();
      gb_vsync = 1'b1;
      tick(3);
      gb_vsync = 1'b0;
      tick(3);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      gb_px_clk = 1'b0;
      gb_hsync  = 1'b0;
      gb_vsync  = 1'b0;
      gb_dat    = 2'd0;
      tick(3);
      rst = 1'b0;
      tick(3);
      exp_q.delete();
      fd_cnt       = 0;
      first_we_cyc = -1;
   endtask

   // Full frame with data (col+line)%4 and HSYNC between lines.
   task automatic send_frame();
      vframe();
      for (int l = 0; l < V; l++) begin
         for (int c = 0; c < H; c++) begin
            expect_px(l, c, 2'((c + l) % 4));
            if (l == 0 && c == 0) first_fall = fall_cyc;
         end
         if (l < V - 1) hline();
      end
   endtask

   initial begin
      tick(4);
      check("rst_we", 32'(fb_we), 0);
      rst = 1'b0;
      tick(2);
      check("rst_waddr", 32'(fb_waddr), 0);
      check("rst_wdata", 32'(fb_wdata), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_gb_on", 32'(gb_on), 0);
      check("rst_overrun", 32'(overrun), 0);

      // Complete frame.
      do_reset();
      send_frame();
      tick(4);
      check("frame_sb_empty", exp_q.size(), 0);
      check("frame_done_count", fd_cnt, 1);
      check("frame_gb_on", 32'(gb_on), 1);
      check("frame_overrun", 32'(overrun), 0);
      // fb_we shows in the 4th clk cycle counting the one in which px_clk fell.
      check("first_we_latency", first_we_cyc - first_fall, 3);

      // Too many strobes on line 0.
      do_reset();
      vframe();
      for (int c = 0; c < H; c++) expect_px(0, c, 2'(c % 4));
      check("long_line_overrun_before", 32'(overrun), 0);
      for (int c = 0; c < 5; c++) pixel(2'd3);
      check("long_line_overrun_after", 32'(overrun), 1);
      hline();
      expect_px(1, 0, 2'd2);
      tick(4);
      check("long_line_sb_empty", exp_q.size(), 0);

      // VSYNC mid-frame at line 2, col 3.
      do_reset();
      vframe();
      for (int l = 0; l < 3; l++) begin
         for (int c = 0; c < ((l < 2) ? H : 3); c++) expect_px(l, c, 2'((c + l) % 4));
         if (l < 2) hline();
      end
      check("trunc_overrun_before", 32'(overrun), 0);
      vframe();
      check("trunc_overrun_after", 32'(overrun), 1);
      expect_px(0, 0, 2'd1);
      tick(4);
      check("trunc_sb_empty", exp_q.size(), 0);
      check("trunc_no_frame_done", fd_cnt, 0);

      // Timeout after a complete frame.
      do_reset();
      send_frame();
      tick(1);
      check("to_gb_on_before", 32'(gb_on), 1);
      to_fall = -1;
      for (int i = 0; i < TO + 100; i++) begin
         tick(1);
         if (!gb_on) begin
            to_fall = cyc;
            break;
         end
      end
      check("timeout_len", to_fall - last_we_cyc, TO);
      for (int i = 0; i < 3; i++) pixel(2'd2);
      check("to_idle_overrun", 32'(overrun), 0);
      vframe();
      expect_px(0, 0, 2'd3);
      tick(4);
      check("to_sb_empty", exp_q.size(), 0);
      check("to_gb_on_after", 32'(gb_on), 0);

      // Reset while the write to address 13 is on the outputs.
      do_reset();
      vframe();
      for (int c = 0; c < H; c++) expect_px(0, c, 2'(c % 4));
      pixel(2'd1);
      hline();
      for (int c = 0; c < 5; c++) expect_px(1, c, 2'((c + 1) % 4));
      tick(2);
      check("mid_sb_empty", exp_q.size(), 0);
      gb_dat    = 2'd3;
      gb_px_clk = 1'b1;
      tick(3);
      gb_px_clk = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("mid_pre_we", 32'(fb_we), 1);
      check("mid_pre_waddr", 32'(fb_waddr), 13);
      check("mid_pre_overrun", 32'(overrun), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_we", 32'(fb_we), 0);
      check("mid_rst_waddr", 32'(fb_waddr), 0);
      check("mid_rst_wdata", 32'(fb_wdata), 0);
      check("mid_rst_overrun", 32'(overrun), 0);
      check("mid_rst_gb_on", 32'(gb_on), 0);
      tick(2);
      rst = 1'b0;
      tick(3);
      pixel(2'd1);
      pixel(2'd2);
      check("post_rst_overrun", 32'(overrun), 0);
      vframe();
      expect_px(0, 0, 2'd2);
      tick(4);
      check("post_rst_sb_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
